// File: rtl/i2cmb_wb_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2cmb_wb_sequencer: turns I2C transaction requests into i2cmb CSR/DPR/CMDR  |
// | Wishbone accesses, paced by irq_i.            Revision: 1.0                 |
// +----------------------------------------------------------------------------+
module i2cmb_wb_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_rw,
  input  logic [3:0]               req_bus,
  input  logic [6:0]               req_addr,
  input  logic [7:0]               req_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [7:0]               wr_data,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  output logic                     done,
  output logic [2:0]               status,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i,
  input  logic                     irq_i
);
  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_RDACK  = 8'h02;
  localparam logic [7:0] CMD_RDNAK  = 8'h03;
  localparam logic [7:0] CMD_START  = 8'h04;
  localparam logic [7:0] CMD_STOP   = 8'h05;
  localparam logic [7:0] CMD_SETBUS = 8'h06;
  localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);
  localparam logic [2:0] ST_OK = 3'd0, ST_ADDR_NAK = 3'd1, ST_DATA_NAK = 3'd2;
  localparam logic [2:0] ST_ARB_LOST = 3'd3, ST_ERR = 3'd4, ST_TIMEOUT = 3'd5;
  localparam logic [24:0] TMO_LAST = 25'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_BUSDPR, S_ADRDPR, S_WRWAIT, S_WRDPR,
    S_CMDW, S_IRQ, S_CMDR, S_EVAL, S_DPRR, S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [7:0]               cmd_q, cmd_d, rem_q, rem_d, wdat_q, wdat_d, rd_data_q, rd_data_d;
  logic [3:0]               bus_q, bus_d;
  logic [6:0]               addr_q, addr_d;
  logic [2:0]               stat_q, stat_d;
  logic [24:0]              tmr_q, tmr_d;
  logic                     rw_q, rw_d, addr_ph_q, addr_ph_d, rd_valid_q, rd_valid_d;
  logic                     s_nak_q, s_nak_d, s_al_q, s_al_d, s_err_q, s_err_d;
  logic                     cyc_q, cyc_d, we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  logic                     x_req, x_we, w_ack, wr_ready_w;
  logic [WB_ADDR_WIDTH-1:0] x_adr;
  logic [7:0]               x_dat;

  assign w_ack = cyc_q & ack_i;

  always_comb begin
    state_d = state_q;   cmd_d = cmd_q;     rem_d = rem_q;     wdat_d = wdat_q;
    bus_d = bus_q;       addr_d = addr_q;   rw_d = rw_q;       stat_d = stat_q;
    tmr_d = tmr_q;       addr_ph_d = addr_ph_q;
    s_nak_d = s_nak_q;   s_al_d = s_al_q;   s_err_d = s_err_q;
    rd_valid_d = 1'b0;   rd_data_d = rd_data_q;
    x_req = 1'b0;        x_we = 1'b0;       x_adr = A_CSR;     x_dat = 8'h00;
    wr_ready_w = 1'b0;
    case (state_q)
      S_INIT: begin
        x_req = 1'b1; x_we = 1'b1; x_adr = A_CSR; x_dat = 8'hC0;
        if (w_ack) state_d = S_IDLE;
      end
      S_IDLE: if (req_valid) begin
        rw_d = req_rw; bus_d = req_bus; addr_d = req_addr; rem_d = req_len;
        stat_d = ST_OK; state_d = S_BUSDPR;
      end
      S_BUSDPR: begin
        x_req = 1'b1; x_we = 1'b1; x_adr = A_DPR; x_dat = {4'h0, bus_q};
        if (w_ack) begin cmd_d = CMD_SETBUS; state_d = S_CMDW; end
      end
      S_ADRDPR: begin
        x_req = 1'b1; x_we = 1'b1; x_adr = A_DPR; x_dat = {addr_q, rw_q};
        if (w_ack) begin cmd_d = CMD_WRITE; addr_ph_d = 1'b1; state_d = S_CMDW; end
      end
      S_WRWAIT: if (wr_valid) begin
        wr_ready_w = 1'b1; wdat_d = wr_data; state_d = S_WRDPR;
      end
      S_WRDPR: begin
        x_req = 1'b1; x_we = 1'b1; x_adr = A_DPR; x_dat = wdat_q;
        if (w_ack) begin cmd_d = CMD_WRITE; state_d = S_CMDW; end
      end
      S_CMDW: begin
        x_req = 1'b1; x_we = 1'b1; x_adr = A_CMDR; x_dat = cmd_q;
        if (w_ack) begin tmr_d = '0; state_d = S_IRQ; end
      end
      S_IRQ: begin
        if (irq_i) state_d = S_CMDR;
        else if (tmr_q == TMO_LAST) begin stat_d = ST_TIMEOUT; state_d = S_DONE; end
        else tmr_d = tmr_q + 25'd1;
      end
      S_CMDR: begin
        x_req = 1'b1; x_adr = A_CMDR;
        if (w_ack) begin
          s_nak_d = dat_i[6]; s_al_d = dat_i[5]; s_err_d = dat_i[4]; state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        addr_ph_d = 1'b0;
        // Arbitration loss and bus error end the transaction without a Stop.
        if (s_al_q) begin stat_d = ST_ARB_LOST; state_d = S_DONE; end
        else if (s_err_q) begin stat_d = ST_ERR; state_d = S_DONE; end
        else begin
          case (cmd_q)
            CMD_SETBUS: begin cmd_d = CMD_START; state_d = S_CMDW; end
            CMD_START:  state_d = S_ADRDPR;
            CMD_WRITE: begin
              if (s_nak_q) begin
                stat_d = addr_ph_q ? ST_ADDR_NAK : ST_DATA_NAK;
                cmd_d = CMD_STOP; state_d = S_CMDW;
              end else if (addr_ph_q) begin
                if (rem_q == 8'd0) begin cmd_d = CMD_STOP; state_d = S_CMDW; end
                else if (rw_q) begin
                  cmd_d = (rem_q == 8'd1) ? CMD_RDNAK : CMD_RDACK; state_d = S_CMDW;
                end else state_d = S_WRWAIT;
              end else begin
                rem_d = rem_q - 8'd1;
                if (rem_q == 8'd1) begin cmd_d = CMD_STOP; state_d = S_CMDW; end
                else state_d = S_WRWAIT;
              end
            end
            CMD_RDACK, CMD_RDNAK: state_d = S_DPRR;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_DPRR: begin
        x_req = 1'b1; x_adr = A_DPR;
        if (w_ack) begin
          rd_valid_d = 1'b1; rd_data_d = dat_i[7:0]; rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) cmd_d = CMD_STOP;
          else cmd_d = (rem_q == 8'd2) ? CMD_RDNAK : CMD_RDACK;
          state_d = S_CMDW;
        end
      end
      S_DONE: state_d = (stat_q == ST_TIMEOUT) ? S_INIT : S_IDLE;
      default: state_d = S_INIT;
    endcase

    // Single Wishbone transfer engine; the idle cycle after each ack gives the cyc gap.
    cyc_d = cyc_q; we_d = we_q; adr_d = adr_q; dat_d = dat_q;
    if (w_ack) cyc_d = 1'b0;
    else if (!cyc_q && x_req) begin
      cyc_d = 1'b1; we_d = x_we; adr_d = x_adr; dat_d = WB_DATA_WIDTH'(x_dat);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_INIT;  cmd_q <= '0;     rem_q <= '0;      wdat_q <= '0;
      bus_q <= '0;        addr_q <= '0;    rw_q <= 1'b0;     stat_q <= '0;
      tmr_q <= '0;        addr_ph_q <= 1'b0;
      s_nak_q <= 1'b0;    s_al_q <= 1'b0;  s_err_q <= 1'b0;
      rd_valid_q <= 1'b0; rd_data_q <= '0;
      cyc_q <= 1'b0;      we_q <= 1'b0;    adr_q <= '0;      dat_q <= '0;
    end else begin
      state_q <= state_d;    cmd_q <= cmd_d;     rem_q <= rem_d;     wdat_q <= wdat_d;
      bus_q <= bus_d;        addr_q <= addr_d;   rw_q <= rw_d;       stat_q <= stat_d;
      tmr_q <= tmr_d;        addr_ph_q <= addr_ph_d;
      s_nak_q <= s_nak_d;    s_al_q <= s_al_d;   s_err_q <= s_err_d;
      rd_valid_q <= rd_valid_d; rd_data_q <= rd_data_d;
      cyc_q <= cyc_d;        we_q <= we_d;       adr_q <= adr_d;     dat_q <= dat_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign status    = done ? stat_q : 3'd0;
  assign wr_ready  = wr_ready_w;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign cyc_o     = cyc_q;
  assign stb_o     = cyc_q;
  assign we_o      = we_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
endmodule
`default_nettype wire

// File: tb/tb_i2cmb_wb_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_i2cmb_wb_sequencer: directed bench with a small i2cmb register model.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_i2cmb_wb_sequencer;
  logic       clk, rst;
  logic       req_valid, req_ready, req_rw;
  logic [3:0] req_bus;
  logic [6:0] req_addr;
  logic [7:0] req_len;
  logic       wr_valid, wr_ready, rd_valid, done;
  logic [7:0] wr_data, rd_data;
  logic [2:0] status;
  logic       cyc_o, stb_o, we_o, ack_i, irq_i;
  logic [1:0] adr_o;
  logic [7:0] dat_o, dat_i;

  i2cmb_wb_sequencer #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_bus(req_bus), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .status(status),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int checks = 0, errors = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Controller model: acks one cycle after a request, raises irq 3 cycles after a command.
  logic [9:0] wlog [256];
  int         wlog_n = 0, rd_ptr = 0, irq_cnt = 0, last_cmdw = 0;
  logic [7:0] rmem [64];
  logic [7:0] dpr_w, stat_r, rd_byte;
  logic [7:0] start_stat = 8'h80;
  logic       addr_next, irq_kill = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_i <= 1'b0; irq_i <= 1'b0; irq_cnt <= 0; addr_next <= 1'b0; dat_i <= 8'h00;
    end else begin
      ack_i <= 1'b0;
      if (irq_cnt > 0) begin irq_cnt <= irq_cnt - 1; if (irq_cnt == 1) irq_i <= 1'b1; end
      if (cyc_o && stb_o && !ack_i) begin
        ack_i <= 1'b1;
        if (we_o) begin
          wlog[wlog_n % 256] <= {adr_o, dat_o};
          wlog_n <= wlog_n + 1;
          if (adr_o == 2'd1) dpr_w <= dat_o;
          if (adr_o == 2'd2) begin
            last_cmdw <= cyc_n;
            if (!irq_kill) irq_cnt <= 3;
            case (dat_o)
              8'h04: begin stat_r <= start_stat; addr_next <= 1'b1; end
              8'h01: begin
                stat_r <= (addr_next && dpr_w[7:1] != 7'h12) ? 8'hC0 : 8'h80;
                addr_next <= 1'b0;
              end
              8'h02, 8'h03: begin rd_byte <= rmem[rd_ptr % 64]; rd_ptr <= rd_ptr + 1; stat_r <= 8'h80; end
              default: stat_r <= 8'h80;
            endcase
          end
        end else begin
          if (adr_o == 2'd2) begin dat_i <= stat_r; irq_i <= 1'b0; end
          else if (adr_o == 2'd1) dat_i <= rd_byte;
          else dat_i <= 8'h00;
        end
      end
    end
  end

  // Write-byte source.
  logic [7:0] wmem [64];
  int         wr_ptr = 0, wr_lim = 0;
  assign wr_data  = wmem[wr_ptr % 64];
  assign wr_valid = (wr_ptr < wr_lim);
  initial forever begin
    @(negedge clk);
    if (wr_ready) begin @(posedge clk); #1; wr_ptr = wr_ptr + 1; end
  end

  // Output monitor.
  int         done_cnt = 0, done_at = 0, wr_pulses = 0, rd_n = 0;
  logic [2:0] last_status = 3'd0;
  logic [7:0] rlog [64];
  always @(negedge clk) begin
    if (done) begin done_cnt <= done_cnt + 1; last_status <= status; done_at <= cyc_n; end
    if (rd_valid) begin rlog[rd_n % 64] <= rd_data; rd_n <= rd_n + 1; end
    if (wr_ready) wr_pulses <= wr_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [9:0] ex [$];
  int lb = 0, wp0 = 0, rb = 0;

  task automatic check_log(input string tag);
    int n;
    n = wlog_n - lb;
    check({tag, "_nwr"}, n, ex.size());
    for (int i = 0; i < ex.size() && i < n; i++)
      check($sformatf("%s_wr%0d", tag, i), 32'(wlog[(lb + i) % 256]), 32'(ex[i]));
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!req_ready && k < 400) begin @(negedge clk); #1; k++; end
  endtask

  task automatic run_txn(input logic rw, input logic [3:0] bus, input logic [6:0] a,
                         input logic [7:0] len);
    int d0, k;
    lb = wlog_n; d0 = done_cnt; wp0 = wr_pulses; rb = rd_n;
    wait_ready();
    check("req_ready", req_ready, 1);
    req_valid = 1'b1; req_rw = rw; req_bus = bus; req_addr = a; req_len = len;
    @(posedge clk); #1; req_valid = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 2000) begin @(negedge clk); #1; k++; end
    check("done_cnt", done_cnt - d0, 1);
  endtask

  task automatic load_wr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
    wmem[wr_ptr % 64] = b0; wmem[(wr_ptr + 1) % 64] = b1; wmem[(wr_ptr + 2) % 64] = b2;
    wr_lim = wr_ptr + n;
  endtask

  initial begin
    int d0, k, lat;
    rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_bus = 4'h0; req_addr = 7'h0; req_len = 8'h0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outs", {cyc_o, stb_o, we_o, req_ready, done, rd_valid, wr_ready, status, adr_o, dat_o}, 0);
    rst = 1'b0;
    wait_ready();
    check("init_ready", req_ready, 1);
    ex = '{10'h0C0};
    check_log("init");

    // Write bus 2, addr 0x12, 3 bytes.
    load_wr(8'hA5, 8'h5A, 8'hFF, 3);
    run_txn(1'b0, 4'd2, 7'h12, 8'd3);
    check("wr_status", last_status, 0);
    check("wr_pulses", wr_pulses - wp0, 3);
    ex = '{10'h102, 10'h206, 10'h204, 10'h124, 10'h201, 10'h1A5, 10'h201,
           10'h15A, 10'h201, 10'h1FF, 10'h201, 10'h205};
    check_log("wr3");

    // Read 2 bytes.
    rmem[rd_ptr % 64] = 8'h3C; rmem[(rd_ptr + 1) % 64] = 8'hC3;
    run_txn(1'b1, 4'd2, 7'h12, 8'd2);
    check("rd_status", last_status, 0);
    check("rd_count", rd_n - rb, 2);
    check("rd_byte0", rlog[rb % 64], 8'h3C);
    check("rd_byte1", rlog[(rb + 1) % 64], 8'hC3);
    ex = '{10'h102, 10'h206, 10'h204, 10'h125, 10'h201, 10'h202, 10'h203, 10'h205};
    check_log("rd2");

    // Unanswered address.
    load_wr(8'h11, 8'h22, 8'h33, 2);
    run_txn(1'b0, 4'd2, 7'h13, 8'd2);
    check("nak_status", last_status, 1);
    check("nak_pulses", wr_pulses - wp0, 0);
    ex = '{10'h102, 10'h206, 10'h204, 10'h126, 10'h201, 10'h205};
    check_log("nak");
    wr_lim = wr_ptr;

    // Address-only probe.
    run_txn(1'b0, 4'd5, 7'h12, 8'd0);
    check("probe_status", last_status, 0);
    check("probe_pulses", wr_pulses - wp0, 0);
    ex = '{10'h105, 10'h206, 10'h204, 10'h124, 10'h201, 10'h205};
    check_log("probe");

    // Arbitration loss outranks ERR and NAK; no Stop.
    start_stat = 8'hF0;
    run_txn(1'b0, 4'd2, 7'h12, 8'd1);
    check("al_status", last_status, 3);
    ex = '{10'h102, 10'h206, 10'h204};
    check_log("al");

    // ERR outranks NAK; no Stop.
    start_stat = 8'hD0;
    run_txn(1'b1, 4'd2, 7'h12, 8'd1);
    check("err_status", last_status, 4);
    ex = '{10'h102, 10'h206, 10'h204};
    check_log("err");
    start_stat = 8'h80;

    // irq never arrives.
    irq_kill = 1'b1;
    run_txn(1'b0, 4'd2, 7'h12, 8'd0);
    check("to_status", last_status, 5);
    ex = '{10'h102, 10'h206};
    check_log("to");
    lat = done_at - last_cmdw;
    check("to_latency_ok", (lat >= 64 && lat <= 68) ? 1 : 0, 1);
    irq_kill = 1'b0;
    run_txn(1'b0, 4'd2, 7'h12, 8'd0);
    check("after_to_status", last_status, 0);
    ex = '{10'h0C0, 10'h102, 10'h206, 10'h204, 10'h124, 10'h201, 10'h205};
    check_log("after_to");

    // Reset while the second data byte is being transferred.
    load_wr(8'h11, 8'h22, 8'h33, 3);
    d0 = done_cnt; wp0 = wr_pulses;
    wait_ready();
    req_valid = 1'b1; req_rw = 1'b0; req_bus = 4'd2; req_addr = 7'h12; req_len = 8'd3;
    @(posedge clk); #1; req_valid = 1'b0;
    k = 0;
    while (wr_pulses - wp0 < 2 && k < 2000) begin @(negedge clk); #1; k++; end
    k = 0;
    while (!cyc_o && k < 50) begin @(negedge clk); #1; k++; end
    check("rst_pre_cyc", cyc_o, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_cyc_stb", {cyc_o, stb_o}, 0);
    repeat (3) @(negedge clk);
    lb = wlog_n;
    wr_lim = wr_ptr;
    #1 rst = 1'b0;
    wait_ready();
    check("rst_no_done", done_cnt - d0, 0);
    ex = '{10'h0C0};
    check_log("rst_init");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
